// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial shift controller.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_BIT_CYCLES = 4;

endpackage

// File: rtl/shift_register.sv
// WIDTH-stage right-shift register built from individual flops with synchronous clear.
// Per-stage priority: sync_reset > load > shift > hold. Stage WIDTH-1 shifts in 0.
module shift_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync_reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Zero-padded above the MSB so every stage can read its upper neighbour uniformly.
  logic [WIDTH:0] chain;
  assign chain = {1'b0, q};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
    logic bit_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        bit_reg <= 1'b0;
      end else if (sync_reset) begin
        bit_reg <= 1'b0;
      end else if (load) begin
        bit_reg <= d[gi];
      end else if (shift) begin
        bit_reg <= chain[gi+1];
      end
    end

    assign q[gi] = bit_reg;
  end

endmodule

// File: rtl/serial_shift_ctrl.sv
// Parallel-to-serial controller: accepts a word over valid/ready and emits it LSB
// first, each bit held BIT_CYCLES clocks, followed by a one-cycle done pulse.
module serial_shift_ctrl
  import serial_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W  = $clog2(WIDTH);
  localparam int TICK_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_CYCLES - 1);

  state_t              state_reg, state_next;
  logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [TICK_W-1:0]   tick_cnt_reg, tick_cnt_next;
  logic [WIDTH-1:0]    sr_q;
  logic                sr_load, sr_shift, sr_clear;
  logic                tick_term, bit_last;

  assign tick_term = (tick_cnt_reg == TICK_LAST);
  assign bit_last  = (bit_cnt_reg == BIT_LAST);

  shift_register #(
    .WIDTH(WIDTH)
  ) u_sr (
    .clk       (clk),
    .reset     (reset),
    .sync_reset(sr_clear),
    .load      (sr_load),
    .shift     (sr_shift),
    .d         (in_data),
    .q         (sr_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      tick_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      tick_cnt_reg <= tick_cnt_next;
    end
  end

  // clear overrides everything, including a pending SHIFT->DONE, so an aborted word never reports done.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    tick_cnt_next = tick_cnt_reg;
    sr_load       = 1'b0;
    sr_shift      = 1'b0;
    sr_clear      = 1'b0;
    if (clear) begin
      state_next    = IDLE;
      sr_clear      = 1'b1;
      bit_cnt_next  = '0;
      tick_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sr_load       = 1'b1;
            bit_cnt_next  = '0;
            tick_cnt_next = '0;
            state_next    = SHIFT;
          end
        end
        SHIFT: begin
          if (tick_term) begin
            sr_shift      = 1'b1;
            tick_cnt_next = '0;
            if (bit_last) begin
              bit_cnt_next = '0;
              state_next   = DONE;
            end else begin
              bit_cnt_next = bit_cnt_reg + BIT_W'(1);
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + TICK_W'(1);
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE) && !clear;
  assign ser_valid = (state_reg == SHIFT);
  assign ser_out   = ser_valid & sr_q[0];
  assign busy      = (state_reg == SHIFT) || (state_reg == DONE);
  assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_serial_shift_ctrl.sv
// Bench for serial_shift_ctrl: two instances (8x4 and 4x1) checked every cycle
// against a word-level timing model driven by directed and random stimulus.
module tb_serial_shift_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       clear_a, in_valid_a, in_ready_a, ser_out_a, ser_valid_a, busy_a, done_a;
  logic [7:0] in_data_a;
  logic       clear_b, in_valid_b, in_ready_b, ser_out_b, ser_valid_b, busy_b, done_b;
  logic [3:0] in_data_b;

  serial_shift_ctrl #(.WIDTH(8), .BIT_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .clear(clear_a), .in_valid(in_valid_a), .in_data(in_data_a),
    .in_ready(in_ready_a), .ser_out(ser_out_a), .ser_valid(ser_valid_a), .busy(busy_a), .done(done_a)
  );

  serial_shift_ctrl #(.WIDTH(4), .BIT_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .clear(clear_b), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .ser_out(ser_out_b), .ser_valid(ser_valid_b), .busy(busy_b), .done(done_b)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Word-level model: a word accepted at an edge occupies offsets 1..W*B (data),
  // W*B+1 (done); everything else is idle.
  int m_w[2] = '{8, 4};
  int m_b[2] = '{4, 1};
  bit m_busy[2];
  int m_off[2];
  int m_word[2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic rdy, input logic so, input logic sv,
                            input logic bz, input logic dn, input logic clr);
    int  span;
    logic e_sv, e_so, e_dn, e_bz, e_rdy;
    span  = m_w[i] * m_b[i];
    e_sv  = m_busy[i] && m_off[i] >= 1 && m_off[i] <= span;
    e_so  = e_sv ? logic'((m_word[i] >> ((m_off[i] - 1) / m_b[i])) & 1) : 1'b0;
    e_dn  = m_busy[i] && m_off[i] == span + 1;
    e_bz  = m_busy[i];
    e_rdy = !m_busy[i] && !clr;
    check_val($sformatf("i%0d c%0d in_ready", i, cyc), 32'(rdy), 32'(e_rdy));
    check_val($sformatf("i%0d c%0d ser_out", i, cyc), 32'(so), 32'(e_so));
    check_val($sformatf("i%0d c%0d ser_valid", i, cyc), 32'(sv), 32'(e_sv));
    check_val($sformatf("i%0d c%0d busy", i, cyc), 32'(bz), 32'(e_bz));
    check_val($sformatf("i%0d c%0d done", i, cyc), 32'(dn), 32'(e_dn));
  endtask

  task automatic model_edge(input int i, input logic v, input int data, input logic clr);
    if (clr) begin
      if (m_busy[i]) $display("inst %0d cycle %0d: word %0h aborted by clear", i, cyc, m_word[i]);
      m_busy[i] = 1'b0;
    end else if (m_busy[i]) begin
      m_off[i]++;
      if (m_off[i] > m_w[i] * m_b[i] + 1) begin
        m_busy[i] = 1'b0;
      end
    end else if (v) begin
      m_busy[i] = 1'b1;
      m_off[i]  = 1;
      m_word[i] = data;
      $display("inst %0d cycle %0d: accepted word %0h", i, cyc, data);
    end
  endtask

  // Called just after a rising edge: drive, check at the falling edge, advance model at the next rising edge.
  task automatic cycle(input logic va, input logic [7:0] da, input logic ca,
                       input logic vb, input logic [3:0] db, input logic cb);
    in_valid_a = va; in_data_a = da; clear_a = ca;
    in_valid_b = vb; in_data_b = db; clear_b = cb;
    @(negedge clk);
    check_inst(0, in_ready_a, ser_out_a, ser_valid_a, busy_a, done_a, ca);
    check_inst(1, in_ready_b, ser_out_b, ser_valid_b, busy_b, done_b, cb);
    @(posedge clk);
    cyc++;
    model_edge(0, va, int'(da), ca);
    model_edge(1, vb, int'(db), cb);
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    clear_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0;
    clear_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;
    m_busy = '{1'b0, 1'b0};
    m_off  = '{0, 0};
    m_word = '{0, 0};
    repeat (2) @(posedge clk);
    #1;
    check_val("reset in_ready_a", 32'(in_ready_a), 32'd1);
    check_val("reset busy_a", 32'(busy_a), 32'd0);
    check_val("reset ser_valid_b", 32'(ser_valid_b), 32'd0);
    reset = 1'b0;

    // Single words: A5 on the 8x4 instance, 4'b1100 on the 4x1 instance.
    cycle(1'b1, 8'hA5, 1'b0, 1'b1, 4'b1100, 1'b0);
    idle(36);

    // Producer holds valid; the second word must wait for DONE+IDLE.
    for (int c = 0; c < 72; c++)
      cycle(1'b1, (c < 1) ? 8'h01 : 8'h80, 1'b0, 1'b1, 4'($urandom), 1'b0);
    idle(4);

    // Abort during bit 3 of an FF word, then a full 3C transfer.
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 4'h0, 1'b0);
    idle(12);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0, 1'b0, 4'h0, 1'b0);
    idle(36);

    // clear and in_valid together while idle: word must not be taken.
    cycle(1'b1, 8'h55, 1'b1, 1'b1, 4'h9, 1'b1);
    idle(2);

    // Asynchronous reset mid-shift, outputs checked before the next edge.
    cycle(1'b1, 8'hC3, 1'b0, 1'b1, 4'h6, 1'b0);
    idle(10);
    #2 reset = 1'b1;
    #1;
    check_val("async rst in_ready_a", 32'(in_ready_a), 32'd1);
    check_val("async rst ser_out_a", 32'(ser_out_a), 32'd0);
    check_val("async rst ser_valid_a", 32'(ser_valid_a), 32'd0);
    check_val("async rst busy_a", 32'(busy_a), 32'd0);
    check_val("async rst done_a", 32'(done_a), 32'd0);
    reset = 1'b0;
    m_busy = '{1'b0, 1'b0};
    cycle(1'b1, 8'h5A, 1'b0, 1'b0, 4'h0, 1'b0);
    idle(36);

    // Random traffic with occasional clears.
    for (int c = 0; c < 3000; c++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 39) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_shift_ctrl.md
# serial_shift_ctrl

Controller that sequences a WIDTH-bit shift register built from per-bit flip-flops with synchronous clear, turning a parallel word into a timed serial bit stream. Sits between a parallel producer (valid/ready handshake) and a single-wire serial consumer. It also drives the stage-level synchronous clear so software/FSM logic can abort a transfer without a full reset.

## Interface
Parameters:
- WIDTH, 8, bits per word (≥2)
- BIT_CYCLES, 4, clock cycles each bit is held on ser_out (≥1)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; one clock domain only
- clear  input  1  synchronous abort/clear command, active-high
- in_valid  input  1  producer has a word on in_data
- in_data  input  WIDTH  parallel word, LSB transmitted first
- in_ready  output  1  block can accept a word this cycle
- ser_out  output  1  current serial bit
- ser_valid  output  1  ser_out carries a data bit
- busy  output  1  transfer in progress (SHIFT or DONE)
- done  output  1  one-cycle pulse after last bit

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready = !clear. Transfer on edge where in_valid && in_ready: shift register ← in_data, bit_cnt ← 0, tick_cnt ← 0, go SHIFT. in_data ignored otherwise.
- SHIFT: ser_out = sr[0], ser_valid = 1, busy = 1, in_ready = 0. tick_cnt counts 0..BIT_CYCLES-1; on terminal tick: shift right (MSB filled with 0), tick_cnt ← 0, bit_cnt ← bit_cnt+1; if bit_cnt == WIDTH-1 on that tick, go DONE. BIT_CYCLES=1: every cycle is terminal.
- DONE: done = 1, busy = 1, ser_valid = 0, ser_out = 0, in_ready = 0; unconditionally IDLE next edge.
- ser_out = 0 whenever ser_valid = 0.
- clear (any state): next edge → IDLE, shift register cleared via stage synchronous clear, counters 0; done never asserted for an aborted word. clear has priority over in_valid and over the SHIFT→DONE transition.
- reset (async, any time, including mid-shift): immediately state IDLE, register and counters 0, ser_out 0, ser_valid 0, busy 0, done 0; in_ready 1 (if clear low). Partially sent word is lost.
- Counter widths: bit_cnt $clog2(WIDTH), tick_cnt max($clog2(BIT_CYCLES),1); no wrap beyond terminal values.

## Timing
- Accept at edge k → first bit valid in cycle k+1.
- ser_valid high cycles k+1 .. k+WIDTH·BIT_CYCLES; bit i occupies cycles k+1+i·BIT_CYCLES .. k+(i+1)·BIT_CYCLES.
- done high in cycle k+WIDTH·BIT_CYCLES+1; in_ready high from cycle k+WIDTH·BIT_CYCLES+2.
- Max throughput: one word per WIDTH·BIT_CYCLES+2 cycles.
- in_ready, ser_out, ser_valid, busy, done depend only on registered state plus clear (in_ready); no in_valid→in_ready combinational path.

## Structure
- Package serial_pkg: state enum (IDLE, SHIFT, DONE, 2-bit encoding), default WIDTH/BIT_CYCLES constants.
- Sub-module shift_register: WIDTH stages, each a rising-edge flop with synchronous clear; controls load, shift, sync_reset; per-stage priority sync_reset > load > shift > hold.
- Top holds FSM, tick/bit counters, output decode.

## Test plan
- WIDTH=8, BIT_CYCLES=4, in_data=8'hA5 accepted at edge 0 → ser_out 1,0,1,0,0,1,0,1, each held 4 cycles; ser_valid cycles 1–32; done cycle 33 only; in_ready cycle 34.
- in_valid held with 8'h01 then 8'h80 → second word accepted exactly at edge 34; both streams bit-exact, no gap beyond DONE+IDLE.
- clear asserted in cycle 13 (bit 3) of an 8'hFF transfer → IDLE next edge, ser_valid/ser_out 0, no done; following 8'h3C transfers fully.
- clear and in_valid together in IDLE → in_ready 0 that cycle, word not taken, state stays IDLE.
- reset asserted mid-SHIFT between edges → all outputs at reset values before next edge; after release, 8'h5A transfers correctly.
- WIDTH=4, BIT_CYCLES=1, in_data=4'b1100 → ser_out 0,0,1,1 in cycles 1–4, done cycle 5, in_ready cycle 6.
